// File: rtl/dsi_pkg.sv
// Shared DSI checksum constants and the byte-wide CRC-16 step used by the
// streaming engine and by any reference model.
package dsi_pkg;

    localparam logic [15:0] DSI_CRC_POLY = 16'h1021;
    localparam logic [15:0] DSI_CRC_INIT = 16'hFFFF;

    // Fold one byte into the CRC register. With refin set the register is kept
    // in reflected form, so the byte enters bit 0 first and the polynomial is
    // applied bit-reversed.
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc,
        input logic [7:0]  data_byte,
        input logic [15:0] poly,
        input logic        refin
    );
        logic [15:0] c;
        logic [15:0] rpoly;
        for (int i = 0; i < 16; i++) begin
            rpoly[i] = poly[15-i];
        end
        c = crc;
        if (refin) begin
            c = c ^ {8'h00, data_byte};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
            end
        end else begin
            c = c ^ {data_byte, 8'h00};
            for (int b = 0; b < 8; b++) begin
                c = c[15] ? ((c << 1) ^ poly) : (c << 1);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_crc16_stream_if.sv
// Byte-lane stream bundle used for both the payload input and the
// payload+footer output of the CRC engine.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// The master holds data/keep/last stable while valid && !ready, and never
// withdraws valid before the transfer; ready may be asserted freely.
interface dsi_crc16_stream_if #(
    parameter int BYTES = 4
) ();

    logic                 valid;
    logic                 ready;
    logic [8*BYTES-1:0]   data;
    logic [BYTES-1:0]     keep;
    logic                 last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);

endinterface

// File: rtl/crc16_dn_comb.sv
// Combinational fold of up to BYTES bytes into a CRC-16 register, lane 0 first.
// Lanes with lane_en low leave the register untouched.
module crc16_dn_comb import dsi_pkg::*; #(
    parameter int          BYTES = 4,
    parameter logic [15:0] POLY  = DSI_CRC_POLY,
    parameter bit          REFIN = 1'b1
) (
    input  logic [15:0]          crc_in,
    input  logic [8*BYTES-1:0]   data,
    input  logic [BYTES-1:0]     lane_en,
    output logic [15:0]          crc_out
);

    // Unrolled chain of byte steps, one per enabled lane, in wire order.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < BYTES; i++) begin
            if (lane_en[i]) begin
                crc_out = crc16_byte(crc_out, data[8*i +: 8], POLY, REFIN);
            end
        end
    end

endmodule

// File: rtl/dsi_crc16_stream.sv
// Streaming DSI long-packet CRC-16: forwards payload beats through a single
// output register and appends the two checksum bytes, packing them into the
// spare lanes of the last beat when they fit, otherwise into one extra beat
// (two single-lane beats when BYTES is 1 and the last beat is full).
module dsi_crc16_stream import dsi_pkg::*; #(
    parameter int          BYTES = 4,
    parameter logic [15:0] POLY  = DSI_CRC_POLY,
    parameter logic [15:0] INIT  = DSI_CRC_INIT,
    parameter bit          REFIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    dsi_crc16_stream_if.slave    s,
    dsi_crc16_stream_if.master   m,
    output logic [15:0]          crc_value,
    output logic                 crc_done,
    output logic [0:0]           dbg_state
);

    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_FOOT = 1'b1;

    logic [0:0]          state;
    logic [15:0]         crc_reg;
    logic [15:0]         crc_next;
    logic [15:0]         pend;
    logic [15:0]         pend_n;
    logic [1:0]          pend_cnt;
    logic [1:0]          cnt_n;
    logic                out_valid;
    logic                out_last;
    logic [8*BYTES-1:0]  out_data;
    logic [BYTES-1:0]    out_keep;
    logic                out_free;
    logic                accept;
    logic                ovf;
    logic [BYTES-1:0]    lane_en;
    int                  keep_cnt;
    logic [8*BYTES-1:0]  pass_data;
    logic [BYTES-1:0]    pass_keep;
    logic                pass_last;
    logic [8*BYTES-1:0]  foot_data;
    logic [BYTES-1:0]    foot_keep;
    logic                foot_last;

    assign out_free  = !out_valid || m.ready;
    assign s.ready   = (state == ST_PASS) && out_free && !clr;
    assign accept    = s.valid && s.ready;
    assign lane_en   = s.last ? s.keep : '1;

    assign m.valid   = out_valid;
    assign m.data    = out_data;
    assign m.keep    = out_keep;
    assign m.last    = out_last;
    assign dbg_state = state;

    crc16_dn_comb #(
        .BYTES (BYTES),
        .POLY  (POLY),
        .REFIN (REFIN)
    ) u_fold (
        .crc_in  (crc_reg),
        .data    (s.data),
        .lane_en (lane_en),
        .crc_out (crc_next)
    );

    // Number of payload bytes in the last beat (keep is contiguous from lane 0).
    always_comb begin
        keep_cnt = 0;
        for (int i = 0; i < BYTES; i++) begin
            if (s.keep[i]) keep_cnt = keep_cnt + 1;
        end
    end

    // Beat built from an accepted input: payload, then footer bytes in the free lanes.
    always_comb begin
        pass_data = '0;
        pass_keep = '0;
        if (!s.last) begin
            pass_data = s.data;
            pass_keep = '1;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (i < keep_cnt) begin
                    pass_data[8*i +: 8] = s.data[8*i +: 8];
                    pass_keep[i]        = 1'b1;
                end else if (i == keep_cnt) begin
                    pass_data[8*i +: 8] = crc_next[7:0];
                    pass_keep[i]        = 1'b1;
                end else if (i == keep_cnt + 1) begin
                    pass_data[8*i +: 8] = crc_next[15:8];
                    pass_keep[i]        = 1'b1;
                end
            end
        end
        ovf       = s.last && (keep_cnt >= BYTES - 1);
        pass_last = s.last && !ovf;
        pend_n    = (keep_cnt == BYTES) ? crc_next : {8'h00, crc_next[15:8]};
        cnt_n     = (keep_cnt == BYTES) ? 2'd2 : 2'd1;
    end

    // Beat carrying leftover footer bytes from lane 0 up.
    always_comb begin
        foot_data = '0;
        foot_keep = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < 2 && i < int'(pend_cnt)) begin
                foot_data[8*i +: 8] = (i == 0) ? pend[7:0] : pend[15:8];
                foot_keep[i]        = 1'b1;
            end
        end
        foot_last = int'(pend_cnt) <= BYTES;
    end

    // CRC register, PASS/FOOT sequencing, output slice and checksum report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PASS;
            crc_reg   <= INIT;
            pend      <= '0;
            pend_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            crc_value <= 16'hFFFF;
            crc_done  <= 1'b0;
        end else if (clr) begin
            state     <= ST_PASS;
            crc_reg   <= INIT;
            pend_cnt  <= '0;
            out_valid <= 1'b0;
            crc_done  <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            if (out_valid && m.ready) out_valid <= 1'b0;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= pass_data;
                out_keep  <= pass_keep;
                out_last  <= pass_last;
                if (s.last) begin
                    crc_reg   <= INIT;
                    crc_value <= crc_next;
                    crc_done  <= 1'b1;
                    if (ovf) begin
                        state    <= ST_FOOT;
                        pend     <= pend_n;
                        pend_cnt <= cnt_n;
                    end
                end else begin
                    crc_reg <= crc_next;
                end
            end else if (state == ST_FOOT && out_free) begin
                out_valid <= 1'b1;
                out_data  <= foot_data;
                out_keep  <= foot_keep;
                out_last  <= foot_last;
                pend      <= {8'h00, pend[15:8]};
                pend_cnt  <= pend_cnt - 2'd1;
                if (foot_last) state <= ST_PASS;
            end
        end
    end

endmodule

// File: tb/tb_dsi_crc16_stream.sv
// Bench for dsi_crc16_stream: BYTES=4 instance driven from a vector table,
// an abort sequence, random backpressure traffic and an async reset, plus a
// BYTES=1 instance for the single-lane footer sequence.
`timescale 1ns/1ps
module tb_dsi_crc16_stream;
    import dsi_pkg::*;

    localparam int W = 8*4 + 4 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic clr1 = 1'b0;
    always #5 clk = ~clk;

    dsi_crc16_stream_if #(.BYTES(4)) s4 ();
    dsi_crc16_stream_if #(.BYTES(4)) m4 ();
    dsi_crc16_stream_if #(.BYTES(1)) s1 ();
    dsi_crc16_stream_if #(.BYTES(1)) m1 ();

    logic [15:0] crc_value4, crc_value1;
    logic        crc_done4, crc_done1;
    logic [0:0]  dbg4, dbg1;

    dsi_crc16_stream #(.BYTES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s(s4), .m(m4),
        .crc_value(crc_value4), .crc_done(crc_done4), .dbg_state(dbg4)
    );

    dsi_crc16_stream #(.BYTES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .s(s1), .m(m1),
        .crc_value(crc_value1), .crc_done(crc_done1), .dbg_state(dbg1)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0]  exp_q[$];
    logic [15:0]   exp_crc_q[$];
    logic [15:0]   last_crc = 16'hFFFF;
    logic [7:0]    pl[$];
    logic [8:0]    cap1[$];
    int            done1 = 0;
    int            rdy_mode = 0;
    logic          mon_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_beat;
    logic [W-1:0]  mon_act, mon_exp;

    typedef struct {
        int          len;
        bit          rnd;
        bit          has_ref;
        logic [15:0] ref_crc;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mask_beat(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x;
        for (int i = 0; i < 4; i++) begin
            if (!y[1+i]) y[5+8*i +: 8] = 8'h00;
        end
        return y;
    endfunction

    // Downstream ready: always on, random, or held off.
    always @(posedge clk) begin
        #1;
        m4.ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
    end

    // Output monitor for the 4-lane instance.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_act = {m4.data, m4.keep, m4.last};
            if (prev_stall) check("stall_hold", {m4.valid, mon_act}, {1'b1, prev_beat});
            if (m4.valid && m4.ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got %0h, expected no beat", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_beat", mask_beat(mon_act), mask_beat(mon_exp));
                end
            end
            prev_stall = m4.valid && !m4.ready;
            prev_beat  = mon_act;
            if (crc_done4) begin
                if (exp_crc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_crc_done: got crc %0h, expected no pulse", crc_value4);
                end else begin
                    check("crc_value", crc_value4, exp_crc_q.pop_front());
                end
            end
        end
    end

    // Capture for the 1-lane instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m1.valid && m1.ready) cap1.push_back({m1.data, m1.last});
            if (crc_done1) done1++;
        end
    end

    task automatic send_beat4(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        s4.valid = 1'b1; s4.data = d; s4.keep = k; s4.last = l;
        do begin
            @(negedge clk);
            n++;
        end while (!s4.ready && n < 500);
        if (!s4.ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: got 0, expected 1");
        end
        @(posedge clk); #1;
        s4.valid = 1'b0;
    endtask

    task automatic send_beat1(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s1.valid = 1'b1; s1.data = d; s1.keep = 1'b1; s1.last = l;
        do begin
            @(negedge clk);
            n++;
        end while (!s1.ready && n < 500);
        if (!s1.ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL s1_ready_timeout: got 0, expected 1");
        end
        @(posedge clk); #1;
        s1.valid = 1'b0;
    endtask

    // Push the expected output beats and checksum, then drive the packet.
    task automatic send_packet4(input logic [7:0] p[$], input logic has_ref, input logic [15:0] ref_crc);
        logic [15:0] f;
        logic [7:0]  ob[$];
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          nb;
        f = DSI_CRC_INIT;
        foreach (p[i]) f = crc16_byte(f, p[i], DSI_CRC_POLY, 1'b1);
        if (has_ref) f = ref_crc;
        exp_crc_q.push_back(f);
        last_crc = f;
        ob = p;
        ob.push_back(f[7:0]);
        ob.push_back(f[15:8]);
        for (int q = 0; q < ob.size(); q += 4) begin
            d = '0; k = '0;
            for (int j = 0; j < 4; j++) begin
                if (q + j < ob.size()) begin
                    d[8*j +: 8] = ob[q+j];
                    k[j] = 1'b1;
                end
            end
            l = (q + 4 >= ob.size());
            exp_q.push_back({d, k, l});
        end
        nb = (p.size() + 3) / 4;
        if (nb == 0) nb = 1;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 4; j++) begin
                if (4*b + j < p.size()) begin
                    d[8*j +: 8] = p[4*b+j];
                    k[j] = 1'b1;
                end
            end
            send_beat4(d, (b == nb-1) ? k : 4'($urandom_range(0, 15)), b == nb-1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_crc_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size() + exp_crc_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        s4.valid = 1'b0; s4.data = '0; s4.keep = '0; s4.last = 1'b0; m4.ready = 1'b1;
        s1.valid = 1'b0; s1.data = '0; s1.keep = '0; s1.last = 1'b0; m1.ready = 1'b1;

        // Reset values
        #12;
        check("rst_m_valid", m4.valid, 0);
        check("rst_m_data", m4.data, 0);
        check("rst_m_keep", m4.keep, 0);
        check("rst_m_last", m4.last, 0);
        check("rst_crc_value", crc_value4, 16'hFFFF);
        check("rst_crc_done", crc_done4, 0);
        check("rst_state", dbg4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_crc_value", crc_value4, 16'hFFFF);
        mon_en = 1'b1;

        // Vector table
        vecs[0] = '{9, 1'b0, 1'b1, 16'h6F91};
        vecs[1] = '{0, 1'b0, 1'b1, 16'hFFFF};
        vecs[2] = '{4, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{2, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{3, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{7, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{8, 1'b1, 1'b0, 16'h0000};
        for (int t = 0; t < 8; t++) begin
            pl.delete();
            for (int j = 0; j < vecs[t].len; j++) begin
                pl.push_back(vecs[t].rnd ? 8'($urandom_range(0, 255)) : 8'(8'h31 + j));
            end
            send_packet4(pl, vecs[t].has_ref, vecs[t].ref_crc);
        end
        drain();

        // Abort after two beats, then resend the full packet
        exp_q.push_back({32'h34333231, 4'hF, 1'b0});
        exp_q.push_back({32'h38373635, 4'hF, 1'b0});
        send_beat4(32'h34333231, 4'hF, 1'b0);
        send_beat4(32'h38373635, 4'hF, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_state", dbg4, 0);
        check("clr_crc_value_kept", crc_value4, last_crc);
        check("clr_m_valid", m4.valid, 0);
        pl.delete();
        for (int j = 0; j < 9; j++) pl.push_back(8'(8'h31 + j));
        send_packet4(pl, 1'b1, 16'h6F91);
        drain();

        // Random packets under backpressure
        rdy_mode = 1;
        for (int t = 0; t < 100; t++) begin
            pl.delete();
            for (int j = 0; j < int'($urandom_range(0, 13)); j++) pl.push_back(8'($urandom_range(0, 255)));
            send_packet4(pl, 1'b0, 16'h0000);
        end
        drain();
        rdy_mode = 0;
        @(posedge clk); #1;

        // Single-lane instance: nine bytes, two footer beats
        for (int j = 0; j < 9; j++) send_beat1(8'(8'h31 + j), j == 8);
        for (int n = 0; n < 20 && cap1.size() < 11; n++) @(negedge clk);
        check("b1_beat_count", cap1.size(), 11);
        if (cap1.size() == 11) begin
            for (int j = 0; j < 9; j++) check("b1_payload", cap1[j], {8'(8'h31 + j), 1'b0});
            check("b1_foot_lo", cap1[9], {8'h91, 1'b0});
            check("b1_foot_hi", cap1[10], {8'h6F, 1'b1});
        end
        check("b1_crc_value", crc_value1, 16'h6F91);
        check("b1_done_count", done1, 1);
        @(posedge clk); #1;

        // Asynchronous reset while an output beat is held
        mon_en = 1'b0;
        rdy_mode = 2;
        @(posedge clk); #1;
        s4.valid = 1'b1; s4.data = 32'hA5A5A5A5; s4.keep = 4'hF; s4.last = 1'b0;
        @(posedge clk); #1;
        s4.valid = 1'b0;
        #1;
        check("pre_rst_valid", m4.valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m4.valid, 0);
        check("mid_rst_m_data", m4.data, 0);
        check("mid_rst_m_keep", m4.keep, 0);
        check("mid_rst_m_last", m4.last, 0);
        check("mid_rst_crc_value", crc_value4, 16'hFFFF);
        check("mid_rst_crc_done", crc_done4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
